// File: rtl/gfx_line_stream_pkg.sv
// Shared definitions for the gfx line rasteriser: FSM states, default
// framebuffer size and the coordinate-width helper.
package gfx_line_stream_pkg;

  typedef enum logic {
    IDLE,
    DRAW
  } line_state_t;

  localparam int DEF_FB_WIDTH  = 640;
  localparam int DEF_FB_HEIGHT = 480;

  // Bits needed to hold a coordinate in 0..n-1, never less than one.
  function automatic int coord_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gfx_line_step.sv
// Combinational Bresenham step: given the current point and error term,
// produce the next point and error. Reusable by other edge walkers.
module gfx_line_step #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int EW = 12
) (
  input  logic [XW-1:0]        x,
  input  logic [YW-1:0]        y,
  input  logic signed [EW-1:0] err,
  input  logic signed [EW-1:0] dx,
  input  logic signed [EW-1:0] dy,
  input  logic                 sx_neg,
  input  logic                 sy_neg,
  output logic [XW-1:0]        x_next,
  output logic [YW-1:0]        y_next,
  output logic signed [EW-1:0] err_next
);

  logic signed [EW:0] e2;
  logic signed [EW:0] dx_w;
  logic signed [EW:0] dy_w;
  logic               step_x;
  logic               step_y;

  // e2 carries one extra bit so 2*err never overflows.
  assign e2   = $signed({err, 1'b0});
  assign dx_w = $signed({dx[EW-1], dx});
  assign dy_w = $signed({dy[EW-1], dy});

  assign step_x = (e2 >= dy_w);
  assign step_y = (e2 <= dx_w);

  assign err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
  assign x_next   = step_x ? (sx_neg ? x - 1'b1 : x + 1'b1) : x;
  assign y_next   = step_y ? (sy_neg ? y - 1'b1 : y + 1'b1) : y;

endmodule

// File: rtl/gfx_line_stream.sv
// All-octant Bresenham line rasteriser on a valid/ready pixel stream.
// Optional macro GFX_LINE_STREAM_CLIP_EN suppresses off-framebuffer pixels.
module gfx_line_stream
  import gfx_line_stream_pkg::*;
#(
  parameter int FB_WIDTH  = DEF_FB_WIDTH,
  parameter int FB_HEIGHT = DEF_FB_HEIGHT,
  parameter int X_BITS    = coord_bits(FB_WIDTH),
  parameter int Y_BITS    = coord_bits(FB_HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_BITS-1:0] x0,
  input  logic [Y_BITS-1:0] y0,
  input  logic [X_BITS-1:0] x1,
  input  logic [Y_BITS-1:0] y1,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              pixel_last,
  output logic              busy,
  output logic              done
);

  localparam int EW = X_BITS + 2;

  line_state_t        state, state_nxt;
  logic [X_BITS-1:0]  x_q, x_nxt, x1_q, x1_nxt, step_x;
  logic [Y_BITS-1:0]  y_q, y_nxt, y1_q, y1_nxt, step_y;
  logic signed [EW-1:0] err_q, err_nxt, dx_q, dx_nxt, dy_q, dy_nxt, step_err;
  logic signed [EW-1:0] ddx, ddy;
  logic               sxn_q, sxn_nxt, syn_q, syn_nxt;
  logic               end_q, end_nxt, done_q, done_nxt;
  logic               visible, advance;

  gfx_line_step #(.XW(X_BITS), .YW(Y_BITS), .EW(EW)) u_step (
    .x        (x_q),
    .y        (y_q),
    .err      (err_q),
    .dx       (dx_q),
    .dy       (dy_q),
    .sx_neg   (sxn_q),
    .sy_neg   (syn_q),
    .x_next   (step_x),
    .y_next   (step_y),
    .err_next (step_err)
  );

`ifdef GFX_LINE_STREAM_CLIP_EN
  assign visible = (int'(x_q) < FB_WIDTH) && (int'(y_q) < FB_HEIGHT);
`else
  assign visible = 1'b1;
`endif

  // Invisible (clipped) pixels step freely; visible ones wait for the sink.
  assign advance = (state == DRAW) && (!visible || pixel_ready);

  assign ddx = $signed({2'b00, x1}) - $signed({2'b00, x0});
  assign ddy = $signed({{(EW-Y_BITS){1'b0}}, y1}) - $signed({{(EW-Y_BITS){1'b0}}, y0});

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    x1_nxt    = x1_q;
    y1_nxt    = y1_q;
    err_nxt   = err_q;
    dx_nxt    = dx_q;
    dy_nxt    = dy_q;
    sxn_nxt   = sxn_q;
    syn_nxt   = syn_q;
    end_nxt   = end_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          dx_nxt    = (ddx < 0) ? -ddx : ddx;
          dy_nxt    = (ddy < 0) ? ddy : -ddy;
          err_nxt   = ((ddx < 0) ? -ddx : ddx) + ((ddy < 0) ? ddy : -ddy);
          sxn_nxt   = !(x0 < x1);
          syn_nxt   = !(y0 < y1);
          x_nxt     = x0;
          y_nxt     = y0;
          x1_nxt    = x1;
          y1_nxt    = y1;
          end_nxt   = (x0 == x1) && (y0 == y1);
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (advance) begin
          if (end_q) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            x_nxt   = step_x;
            y_nxt   = step_y;
            err_nxt = step_err;
            end_nxt = (step_x == x1_q) && (step_y == y1_q);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      err_q  <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      sxn_q  <= 1'b0;
      syn_q  <= 1'b0;
      end_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      x_q    <= x_nxt;
      y_q    <= y_nxt;
      x1_q   <= x1_nxt;
      y1_q   <= y1_nxt;
      err_q  <= err_nxt;
      dx_q   <= dx_nxt;
      dy_q   <= dy_nxt;
      sxn_q  <= sxn_nxt;
      syn_q  <= syn_nxt;
      end_q  <= end_nxt;
      done_q <= done_nxt;
    end
  end

  assign busy        = (state == DRAW);
  assign pixel_valid = busy && visible;
  assign pixel_last  = busy && visible && end_q;
  assign x           = x_q;
  assign y           = y_q;
  assign done        = done_q;

endmodule

// File: tb/tb_gfx_line_stream.sv
// Directed bench for gfx_line_stream: octant coverage, back-pressure,
// degenerate lines, reset abort, busy-start rejection and optional clipping.
module tb_gfx_line_stream;

  logic       clk = 1'b0;
  logic       reset, start, pixel_ready;
  logic [9:0] x0, x1, x;
  logic [8:0] y0, y1, y;
  logic       pixel_valid, pixel_last, busy, done;

  int passCount  = 0;
  int checkCount = 0;

  int px[$];
  int py[$];
  int lastCnt, lastIdx, stableErr, lastHsCyc, doneCyc, firstValidCyc;

  gfx_line_stream dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .x           (x),
    .y           (y),
    .pixel_last  (pixel_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Called on a falling edge; leaves start deasserted just after the edge that takes it.
  task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1);
    x0    = 10'(ax0);
    y0    = 9'(ay0);
    x1    = 10'(ax1);
    y1    = 9'(ay1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Entered just after a rising edge; returns on the falling edge where done is seen.
  task automatic collect(input bit toggle, input int maxPix);
    bit       holdPending = 1'b0;
    bit [9:0] holdX = '0;
    bit [8:0] holdY = '0;
    px.delete();
    py.delete();
    lastCnt = 0; lastIdx = -1; stableErr = 0;
    lastHsCyc = -1; doneCyc = -1; firstValidCyc = -1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      pixel_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk);
      if (done) begin
        doneCyc = cyc;
        return;
      end
      if (holdPending && (!pixel_valid || x != holdX || y != holdY)) stableErr++;
      if (pixel_valid && firstValidCyc < 0) firstValidCyc = cyc;
      holdPending = pixel_valid && !pixel_ready;
      holdX = x;
      holdY = y;
      if (pixel_valid && pixel_ready) begin
        px.push_back(int'(x));
        py.push_back(int'(y));
        lastHsCyc = cyc;
        if (pixel_last) begin
          lastCnt++;
          lastIdx = px.size() - 1;
        end
        if (maxPix > 0 && px.size() == maxPix) return;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("collect_timeout", 1, 0);
  endtask

  task automatic checkDone(input string tag, input int gap, input bit waitNext);
    checkOutput({tag, "_done_gap"}, doneCyc - lastHsCyc, gap);
    checkOutput({tag, "_done_busy"}, int'(busy), 0);
    checkOutput({tag, "_done_valid"}, int'(pixel_valid), 0);
    if (waitNext) begin
      @(negedge clk);
      checkOutput({tag, "_done_once"}, int'(done), 0);
    end
  endtask

  function automatic int lastOf(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; pixel_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", int'(pixel_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_x", int'(x), 0);
    checkOutput("rst_y", int'(y), 0);

    // Horizontal, left to right
    applyStimulus(10, 10, 20, 10);
    collect(1'b0, 0);
    checkOutput("horiz_count", px.size(), 11);
    bad = 0;
    foreach (px[i]) if (px[i] != 10 + i || py[i] != 10) bad++;
    checkOutput("horiz_seq", bad, 0);
    checkOutput("horiz_last_cnt", lastCnt, 1);
    checkOutput("horiz_last_idx", lastIdx, 10);
    checkOutput("horiz_first_lat", firstValidCyc, 0);
    checkDone("horiz", 1, 1'b1);

    // Steep, up and to the left
    applyStimulus(50, 40, 45, 20);
    collect(1'b0, 0);
    checkOutput("steep_count", px.size(), 21);
    bad = 0;
    foreach (px[i]) if (py[i] != 40 - i || (i > 0 && px[i] > px[i-1])) bad++;
    checkOutput("steep_seq", bad, 0);
    checkOutput("steep_end_x", lastOf(px), 45);
    checkOutput("steep_end_y", lastOf(py), 20);
    checkOutput("steep_last_idx", lastIdx, 20);
    checkDone("steep", 1, 1'b1);

    // Diagonal under alternating back-pressure
    applyStimulus(100, 100, 110, 110);
    collect(1'b1, 0);
    checkOutput("diag_count", px.size(), 11);
    bad = 0;
    foreach (px[i]) if (px[i] != 100 + i || py[i] != 100 + i) bad++;
    checkOutput("diag_seq", bad, 0);
    checkOutput("diag_stable", stableErr, 0);
    checkOutput("diag_last_idx", lastIdx, 10);
    checkDone("diag", 1, 1'b1);

    // Degenerate point, then a new line started in the done cycle
    applyStimulus(7, 7, 7, 7);
    collect(1'b0, 0);
    checkOutput("degen_count", px.size(), 1);
    checkOutput("degen_x", lastOf(px), 7);
    checkOutput("degen_last_idx", lastIdx, 0);
    checkDone("degen", 1, 1'b0);
    applyStimulus(0, 0, 3, 0);
    collect(1'b0, 0);
    checkOutput("chain_first_lat", firstValidCyc, 0);
    checkOutput("chain_count", px.size(), 4);
    bad = 0;
    foreach (px[i]) if (px[i] != i || py[i] != 0) bad++;
    checkOutput("chain_seq", bad, 0);
    checkDone("chain", 1, 1'b1);

    // Reset abandons a line part way through
    applyStimulus(200, 200, 210, 200);
    collect(1'b0, 3);
    checkOutput("abort_pre_count", px.size(), 3);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", int'(pixel_valid), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_x", int'(x), 0);
    checkOutput("abort_y", int'(y), 0);
    @(negedge clk);
    checkOutput("abort_no_done", int'(done), 0);

    // Start while busy must be ignored
    pixel_ready = 1'b0;
    applyStimulus(10, 10, 13, 10);
    @(negedge clk);
    checkOutput("busy_busy", int'(busy), 1);
    applyStimulus(300, 300, 300, 400);
    @(negedge clk);
    checkOutput("busy_hold_x", int'(x), 10);
    checkOutput("busy_hold_y", int'(y), 10);
    @(posedge clk);
    #1;
    collect(1'b0, 0);
    checkOutput("busy_count", px.size(), 4);
    bad = 0;
    foreach (px[i]) if (px[i] != 10 + i || py[i] != 10) bad++;
    checkOutput("busy_seq", bad, 0);
    checkDone("busy", 1, 1'b1);
    checkOutput("busy_idle_after", int'(busy), 0);

`ifdef GFX_LINE_STREAM_CLIP_EN
    // Line running off the right edge of the framebuffer
    applyStimulus(630, 10, 645, 10);
    collect(1'b0, 0);
    checkOutput("clip_count", px.size(), 10);
    bad = 0;
    foreach (px[i]) if (px[i] != 630 + i || py[i] != 10) bad++;
    checkOutput("clip_seq", bad, 0);
    checkOutput("clip_last_cnt", lastCnt, 0);
    checkDone("clip", 7, 1'b1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
